// File: rtl/seq_restoring_divider_16.sv
// seq_restoring_divider_16
//   Iterative unsigned divider for the ALU. It uses the restoring algorithm and
//   produces one quotient bit per clock. It returns quotient = dividend / divisor
//   and remainder = dividend % divisor. A zero divisor is caught at capture time
//   and answered in one cycle: quotient = all ones, remainder = dividend,
//   div_by_zero = 1.
// Ports
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   start          request, accepted only while busy=0
//   dividend       operand, captured on an accepted start
//   divisor        operand, captured on an accepted start
//   busy           high while a division is in flight
//   done           one-cycle pulse when the results update
//   quotient       result, held until the next done
//   remainder      result, held until the next done
//   div_by_zero    divide-by-zero flag, held until the next done
module seq_restoring_divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, ZDIV} state_t;

  state_t           state;
  // After each step the partial remainder is always below the divisor, so its
  // top bit is always zero. Only WIDTH bits are stored. The shifted value r_sh
  // carries the full WIDTH+1 bits so that the borrow of the trial subtract is
  // visible.
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;

  // One restoring step. The trial subtract is written as A + ~B + 1. When
  // diff[WIDTH] is set, a borrow occurred: the shifted remainder is kept and
  // the new quotient bit is 0. On the restore path r_sh < divisor, so its top
  // bit is 0 and dropping that bit loses nothing.
  always_comb begin
    r_sh  = {r, q[WIDTH-1]};
    diff  = r_sh + ~{1'b0, dvs} + {{WIDTH{1'b0}}, 1'b1};
    r_nxt = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    q_nxt = {q[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      r           <= '0;
      q           <= '0;
      dvs         <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            r     <= '0;
            q     <= dividend;
            dvs   <= divisor;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= (divisor == '0) ? ZDIV : RUN;
          end
        end
        RUN: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        ZDIV: begin
          // q still holds the captured dividend.
          quotient    <= '1;
          remainder   <= q;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
